// File: rtl/snake_round_sequencer.sv
// snake_round_sequencer
// Central controller for the two-snake game. Generates per-snake move strobes at the
// base or powered rate and runs the round sequence move -> settle frame -> scan frame ->
// evaluate. It arbitrates the single food item between the snakes and owns the lengths,
// power counters and game-over/loser flags. Every output is driven straight from a flop,
// so each strobe appears in the cycle after the condition that causes it.
module snake_round_sequencer #(
    parameter int unsigned BASE_DIV    = 3600000,
    parameter int unsigned POWER_DIV   = 1800000,
    parameter int unsigned POWER_BONUS = 100,
    parameter int unsigned GROW_STEP   = 4,
    parameter int unsigned MAX_LEN     = 128
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       frame_done,
    input  logic       head_a_food,
    input  logic       head_b_food,
    input  logic       hit_a,
    input  logic       hit_b,
    input  logic       super_food,
    output logic       move_a,
    output logic       move_b,
    output logic       clear_flags,
    output logic       food_take,
    output logic       food_owner,
    output logic [6:0] length_a,
    output logic [6:0] length_b,
    output logic [6:0] power_a,
    output logic [6:0] power_b,
    output logic       game_over,
    output logic       red_died,
    output logic       blue_died
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PLAY   = 3'd1,
        MOVE   = 3'd2,
        SETTLE = 3'd3,
        SCAN   = 3'd4,
        OVER   = 3'd5
    } state_t;

    localparam int unsigned BASE_W = (BASE_DIV > 1) ? $clog2(BASE_DIV) : 1;
    localparam int unsigned PWR_W  = (POWER_DIV > 1) ? $clog2(POWER_DIV) : 1;

    localparam logic [BASE_W-1:0] BASE_LAST = BASE_W'(BASE_DIV - 1);
    localparam logic [BASE_W-1:0] BASE_ONE  = BASE_W'(1);
    localparam logic [BASE_W-1:0] BASE_ZERO = {BASE_W{1'b0}};
    localparam logic [PWR_W-1:0]  PWR_LAST  = PWR_W'(POWER_DIV - 1);
    localparam logic [PWR_W-1:0]  PWR_ONE   = PWR_W'(1);
    localparam logic [PWR_W-1:0]  PWR_ZERO  = {PWR_W{1'b0}};

    // A snake only grows while the grown length still fits below MAX_LEN
    localparam logic [6:0] GROW_LIMIT = 7'(MAX_LEN - GROW_STEP);
    localparam logic [6:0] GROW_INC   = 7'(GROW_STEP);
    localparam logic [8:0] POWER_INC  = 9'(POWER_BONUS);

    // Power after a super-food eat, saturating at the 7-bit maximum
    function automatic logic [6:0] power_boost(input logic [6:0] p);
        logic [8:0] sum;
        sum = {2'b00, p} + POWER_INC;
        if (sum > 9'd127) begin
            power_boost = 7'd127;
        end else begin
            power_boost = sum[6:0];
        end
    endfunction

    // Length after a normal-food eat; a snake near capacity stays unchanged
    function automatic logic [6:0] length_grow(input logic [6:0] len);
        if (len < GROW_LIMIT) begin
            length_grow = len + GROW_INC;
        end else begin
            length_grow = len;
        end
    endfunction

    state_t            state_q, state_d;
    logic [BASE_W-1:0] base_cnt_q, base_cnt_d;
    logic [PWR_W-1:0]  pwr_cnt_q, pwr_cnt_d;
    logic              pend_a_q, pend_a_d;
    logic              pend_b_q, pend_b_d;
    logic              move_a_q, move_a_d;
    logic              move_b_q, move_b_d;
    logic              clear_flags_q, clear_flags_d;
    logic              food_take_q, food_take_d;
    logic              food_owner_q, food_owner_d;
    logic [6:0]        length_a_q, length_a_d;
    logic [6:0]        length_b_q, length_b_d;
    logic [6:0]        power_a_q, power_a_d;
    logic [6:0]        power_b_q, power_b_d;
    logic              game_over_q, game_over_d;
    logic              red_died_q, red_died_d;
    logic              blue_died_q, blue_died_d;
    logic              rr_pri_q, rr_pri_d;

    logic              running_s;
    logic              base_tick_s;
    logic              pwr_tick_s;
    logic              due_a_s;
    logic              due_b_s;
    logic              hold_s;
    logic              winner_s;

    // Tick decode: dividers only count while a round is in progress
    always_comb begin
        running_s   = (state_q != IDLE) && (state_q != OVER);
        base_tick_s = running_s && (base_cnt_q == BASE_LAST);
        pwr_tick_s  = running_s && (pwr_cnt_q == PWR_LAST);
        due_a_s     = (power_a_q != 7'd0) ? pwr_tick_s : base_tick_s;
        due_b_s     = (power_b_q != 7'd0) ? pwr_tick_s : base_tick_s;
    end

    // Next-state, round sequencing, food arbitration and scoring
    always_comb begin
        state_d       = state_q;
        base_cnt_d    = (!running_s || base_tick_s) ? BASE_ZERO : (base_cnt_q + BASE_ONE);
        pwr_cnt_d     = (!running_s || pwr_tick_s) ? PWR_ZERO : (pwr_cnt_q + PWR_ONE);
        pend_a_d      = pend_a_q | due_a_s;
        pend_b_d      = pend_b_q | due_b_s;
        move_a_d      = 1'b0;
        move_b_d      = 1'b0;
        clear_flags_d = 1'b0;
        food_take_d   = 1'b0;
        food_owner_d  = food_owner_q;
        length_a_d    = length_a_q;
        length_b_d    = length_b_q;
        power_a_d     = power_a_q;
        power_b_d     = power_b_q;
        game_over_d   = game_over_q;
        red_died_d    = red_died_q;
        blue_died_d   = blue_died_q;
        rr_pri_d      = rr_pri_q;
        winner_s      = 1'b0;
        hold_s        = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = PLAY;
                end else begin
                    state_d = IDLE;
                end
            end
            PLAY: begin
                // The move strobes carry the pends as they will stand in MOVE
                if (pend_a_q || pend_b_q) begin
                    state_d  = MOVE;
                    move_a_d = pend_a_q | due_a_s;
                    move_b_d = pend_b_q | due_b_s;
                end else begin
                    state_d = PLAY;
                end
            end
            MOVE: begin
                // Issued pends retire; a tick landing now re-arms for the next move
                state_d   = SETTLE;
                pend_a_d  = (pend_a_q & ~move_a_q) | due_a_s;
                pend_b_d  = (pend_b_q & ~move_b_q) | due_b_s;
                power_a_d = (move_a_q && (power_a_q != 7'd0)) ? (power_a_q - 7'd1) : power_a_q;
                power_b_d = (move_b_q && (power_b_q != 7'd0)) ? (power_b_q - 7'd1) : power_b_q;
            end
            SETTLE: begin
                if (frame_done) begin
                    state_d       = SCAN;
                    clear_flags_d = 1'b1;
                end else begin
                    state_d = SETTLE;
                end
            end
            SCAN: begin
                if (frame_done) begin
                    red_died_d  = red_died_q | hit_a;
                    blue_died_d = blue_died_q | hit_b;
                    if (head_a_food || head_b_food) begin
                        // A double hit goes to the favoured snake and flips the favour
                        if (head_a_food && head_b_food) begin
                            winner_s = rr_pri_q;
                            rr_pri_d = ~rr_pri_q;
                        end else begin
                            winner_s = head_b_food;
                        end
                        food_take_d  = 1'b1;
                        food_owner_d = winner_s;
                        if (winner_s) begin
                            if (super_food) begin
                                power_b_d = power_boost(power_b_q);
                            end else begin
                                length_b_d = length_grow(length_b_q);
                            end
                        end else begin
                            if (super_food) begin
                                power_a_d = power_boost(power_a_q);
                            end else begin
                                length_a_d = length_grow(length_a_q);
                            end
                        end
                    end else begin
                        food_take_d = 1'b0;
                    end
                    if (hit_a || hit_b) begin
                        state_d     = OVER;
                        game_over_d = 1'b1;
                    end else begin
                        state_d = PLAY;
                    end
                end else begin
                    state_d = SCAN;
                end
            end
            OVER: begin
                if (start) begin
                    state_d     = PLAY;
                    length_a_d  = 7'd1;
                    length_b_d  = 7'd1;
                    power_a_d   = 7'd0;
                    power_b_d   = 7'd0;
                    game_over_d = 1'b0;
                    red_died_d  = 1'b0;
                    blue_died_d = 1'b0;
                end else begin
                    state_d = OVER;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Dividers and pends rest at zero whenever no round is running
        hold_s     = (state_d == IDLE) || (state_d == OVER);
        base_cnt_d = hold_s ? BASE_ZERO : base_cnt_d;
        pwr_cnt_d  = hold_s ? PWR_ZERO : pwr_cnt_d;
        pend_a_d   = hold_s ? 1'b0 : pend_a_d;
        pend_b_d   = hold_s ? 1'b0 : pend_b_d;
    end

    // State, counters and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            base_cnt_q    <= BASE_ZERO;
            pwr_cnt_q     <= PWR_ZERO;
            pend_a_q      <= 1'b0;
            pend_b_q      <= 1'b0;
            move_a_q      <= 1'b0;
            move_b_q      <= 1'b0;
            clear_flags_q <= 1'b0;
            food_take_q   <= 1'b0;
            food_owner_q  <= 1'b0;
            length_a_q    <= 7'd1;
            length_b_q    <= 7'd1;
            power_a_q     <= 7'd0;
            power_b_q     <= 7'd0;
            game_over_q   <= 1'b0;
            red_died_q    <= 1'b0;
            blue_died_q   <= 1'b0;
            rr_pri_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            base_cnt_q    <= base_cnt_d;
            pwr_cnt_q     <= pwr_cnt_d;
            pend_a_q      <= pend_a_d;
            pend_b_q      <= pend_b_d;
            move_a_q      <= move_a_d;
            move_b_q      <= move_b_d;
            clear_flags_q <= clear_flags_d;
            food_take_q   <= food_take_d;
            food_owner_q  <= food_owner_d;
            length_a_q    <= length_a_d;
            length_b_q    <= length_b_d;
            power_a_q     <= power_a_d;
            power_b_q     <= power_b_d;
            game_over_q   <= game_over_d;
            red_died_q    <= red_died_d;
            blue_died_q   <= blue_died_d;
            rr_pri_q      <= rr_pri_d;
        end
    end

    assign move_a      = move_a_q;
    assign move_b      = move_b_q;
    assign clear_flags = clear_flags_q;
    assign food_take   = food_take_q;
    assign food_owner  = food_owner_q;
    assign length_a    = length_a_q;
    assign length_b    = length_b_q;
    assign power_a     = power_a_q;
    assign power_b     = power_b_q;
    assign game_over   = game_over_q;
    assign red_died    = red_died_q;
    assign blue_died   = blue_died_q;

endmodule

// File: tb/tb_snake_round_sequencer.sv
// Directed bench for snake_round_sequencer with short dividers (base 8, powered 4).
module tb_snake_round_sequencer;

    logic       clk = 1'b0;
    logic       rst, start, frame_done;
    logic       head_a_food, head_b_food, hit_a, hit_b, super_food;
    logic       move_a, move_b, clear_flags, food_take, food_owner;
    logic [6:0] length_a, length_b, power_a, power_b;
    logic       game_over, red_died, blue_died;

    int n_checks = 0;
    int n_fail   = 0;
    int n_ma, n_mb, n_a_only, n_b_only;
    int exp_pb = 0;

    typedef struct {
        bit fa;
        bit fb;
        bit exp_take;
        bit exp_owner;
        int exp_la;
        int exp_lb;
    } vec_t;

    vec_t vecs[7];

    snake_round_sequencer #(
        .BASE_DIV(8), .POWER_DIV(4), .POWER_BONUS(100), .GROW_STEP(4), .MAX_LEN(128)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .frame_done(frame_done),
        .head_a_food(head_a_food), .head_b_food(head_b_food),
        .hit_a(hit_a), .hit_b(hit_b), .super_food(super_food),
        .move_a(move_a), .move_b(move_b), .clear_flags(clear_flags),
        .food_take(food_take), .food_owner(food_owner),
        .length_a(length_a), .length_b(length_b),
        .power_a(power_a), .power_b(power_b),
        .game_over(game_over), .red_died(red_died), .blue_died(blue_died)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: actual %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // One clock; sample #1 after the edge, count moves, model power drain, check strobe overlap
    task automatic step();
        int ov;
        @(posedge clk);
        #1;
        if (move_a) n_ma++;
        if (move_b) n_mb++;
        if (move_a && !move_b) n_a_only++;
        if (move_b && !move_a) n_b_only++;
        if (move_b && exp_pb > 0) exp_pb--;
        ov = int'(clear_flags) + int'(food_take) + int'(move_a | move_b);
        check("strobe_overlap", ov > 1 ? ov : 1, 1);
    endtask

    task automatic check_reset_state(input string p);
        check({p, "_move_a"}, int'(move_a), 0);
        check({p, "_move_b"}, int'(move_b), 0);
        check({p, "_clear"}, int'(clear_flags), 0);
        check({p, "_take"}, int'(food_take), 0);
        check({p, "_owner"}, int'(food_owner), 0);
        check({p, "_len_a"}, int'(length_a), 1);
        check({p, "_len_b"}, int'(length_b), 1);
        check({p, "_pow_a"}, int'(power_a), 0);
        check({p, "_pow_b"}, int'(power_b), 0);
        check({p, "_over"}, int'(game_over), 0);
        check({p, "_red_died"}, int'(red_died), 0);
        check({p, "_blue_died"}, int'(blue_died), 0);
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // After the start edge the first move strobe appears exactly 9 edges later
    task automatic check_first_move(input string name);
        n_ma = 0;
        n_mb = 0;
        repeat (8) step();
        check({name, "_no_early_move"}, n_ma + n_mb, 0);
        step();
        check({name, "_first_move_a"}, int'(move_a), 1);
        check({name, "_first_move_b"}, int'(move_b), 1);
    endtask

    task automatic wait_move(input string name);
        int k;
        k = 0;
        while (!(move_a || move_b) && k < 60) begin
            step();
            k++;
        end
        n_checks++;
        if (!(move_a || move_b)) begin
            n_fail++;
            $display("FAIL %s_wait_move: actual no strobe, expected a move within 60 cycles", name);
        end
    endtask

    // Called in the MOVE cycle: settle frame, then scan frame carrying the given flags
    task automatic settle_scan(input bit fa, input bit fb, input bit sup,
                               input bit ha, input bit hb, input string name);
        step();
        frame_done = 1'b1;
        step();
        frame_done = 1'b0;
        check({name, "_clear"}, int'(clear_flags), 1);
        head_a_food = fa;
        head_b_food = fb;
        super_food  = sup;
        hit_a       = ha;
        hit_b       = hb;
        frame_done  = 1'b1;
        step();
        frame_done  = 1'b0;
        head_a_food = 1'b0;
        head_b_food = 1'b0;
        super_food  = 1'b0;
        hit_a       = 1'b0;
        hit_b       = 1'b0;
    endtask

    task automatic round(input bit fa, input bit fb, input bit sup, input bit ha, input bit hb,
                         input string name, output bit ma, output bit mb);
        wait_move(name);
        ma = move_a;
        mb = move_b;
        settle_scan(fa, fb, sup, ha, hb, name);
    endtask

    // Leave free-running frame mode in a MOVE cycle and finish that round cleanly
    task automatic stop_continuous(input string name);
        wait_move(name);
        frame_done = 1'b0;
        settle_scan(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, name);
    endtask

    initial begin
        bit ma, mb;
        int k;

        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1, 1};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 5, 1};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 5, 5};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 9, 5};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 9, 9};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 9, 13};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 9, 13};

        rst = 1'b1;
        start = 1'b0;
        frame_done = 1'b0;
        head_a_food = 1'b0;
        head_b_food = 1'b0;
        hit_a = 1'b0;
        hit_b = 1'b0;
        super_food = 1'b0;
        repeat (3) step();
        check_reset_state("reset");
        rst = 1'b0;

        // IDLE holds without start
        n_ma = 0;
        n_mb = 0;
        repeat (20) step();
        check("idle_no_moves", n_ma + n_mb, 0);

        // Test 1: start, first joint move, settle/scan sequencing
        do_start();
        check_first_move("t1");
        settle_scan(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "t1");
        check("t1_no_take", int'(food_take), 0);
        check("t1_not_over", int'(game_over), 0);

        // Table: food arbitration and growth, unpowered joint moves
        for (int i = 0; i < 7; i++) begin
            round(vecs[i].fa, vecs[i].fb, 1'b0, 1'b0, 1'b0, $sformatf("vec%0d", i), ma, mb);
            check($sformatf("vec%0d_move_a", i), int'(ma), 1);
            check($sformatf("vec%0d_move_b", i), int'(mb), 1);
            check($sformatf("vec%0d_take", i), int'(food_take), int'(vecs[i].exp_take));
            check($sformatf("vec%0d_owner", i), int'(food_owner), int'(vecs[i].exp_owner));
            check($sformatf("vec%0d_len_a", i), int'(length_a), vecs[i].exp_la);
            check($sformatf("vec%0d_len_b", i), int'(length_b), vecs[i].exp_lb);
            check($sformatf("vec%0d_over", i), int'(game_over), 0);
        end

        // Length ceiling: 9 + 28*4 = 121, then 125, then unchanged
        for (int r = 0; r < 28; r++) begin
            round(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "grow", ma, mb);
        end
        check("grow_121", int'(length_a), 121);
        round(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "grow_last", ma, mb);
        check("grow_125", int'(length_a), 125);
        round(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "grow_cap", ma, mb);
        check("grow_cap_len", int'(length_a), 125);
        check("grow_cap_take", int'(food_take), 1);
        check("grow_cap_len_b", int'(length_b), 13);

        // Test 4: super food for blue, saturation, powered rate and drain
        round(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "super1", ma, mb);
        check("super1_pow_b", int'(power_b), 100);
        check("super1_owner", int'(food_owner), 1);
        check("super1_len_b", int'(length_b), 13);
        check("super1_pow_a", int'(power_a), 0);
        exp_pb = 100;
        round(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "drain1", ma, mb);
        check("drain1_pow_b", int'(power_b), exp_pb);
        round(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "super2", ma, mb);
        check("super2_pow_b_sat", int'(power_b), 127);
        exp_pb = 127;

        frame_done = 1'b1;
        n_ma = 0; n_mb = 0; n_a_only = 0; n_b_only = 0;
        repeat (80) step();
        check_range("pwr_rate_b", n_mb, 19, 21);
        check_range("pwr_rate_a", n_ma, 9, 11);
        check("pwr_red_alone", n_a_only, 0);
        k = 0;
        while (power_b != 7'd0 && k < 1000) begin
            step();
            k++;
        end
        check("pwr_drained", int'(power_b), 0);
        check("pwr_model_zero", exp_pb, 0);
        n_ma = 0; n_mb = 0; n_a_only = 0; n_b_only = 0;
        repeat (80) step();
        check_range("base_rate_b", n_mb, 9, 11);
        check("base_rate_equal", n_ma, n_mb);
        check("base_b_alone", n_b_only, 0);
        stop_continuous("pwr_stop");
        check("pwr_stop_pow_b", int'(power_b), 0);
        check("pwr_stop_pow_a", int'(power_a), 0);

        // Test 5: both die -> tie, frozen, restart
        round(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "tie", ma, mb);
        check("tie_over", int'(game_over), 1);
        check("tie_red", int'(red_died), 1);
        check("tie_blue", int'(blue_died), 1);
        check("tie_take", int'(food_take), 0);
        n_ma = 0;
        n_mb = 0;
        repeat (40) step();
        check("over_no_moves", n_ma + n_mb, 0);
        check("over_held", int'(game_over), 1);
        do_start();
        exp_pb = 0;
        check("restart_len_a", int'(length_a), 1);
        check("restart_len_b", int'(length_b), 1);
        check("restart_over", int'(game_over), 0);
        check("restart_red", int'(red_died), 0);
        check("restart_blue", int'(blue_died), 0);
        check_first_move("restart");

        // Red dies while eating: still scores, blue survives
        settle_scan(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "reddie");
        check("reddie_len_a", int'(length_a), 5);
        check("reddie_take", int'(food_take), 1);
        check("reddie_owner", int'(food_owner), 0);
        check("reddie_red", int'(red_died), 1);
        check("reddie_blue", int'(blue_died), 0);
        check("reddie_over", int'(game_over), 1);
        do_start();
        check_first_move("restart2");

        // start during SETTLE is ignored; blue then eats
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        frame_done = 1'b1;
        step();
        frame_done = 1'b0;
        check("ign_start_clear", int'(clear_flags), 1);
        head_b_food = 1'b1;
        frame_done = 1'b1;
        step();
        frame_done = 1'b0;
        head_b_food = 1'b0;
        check("ign_start_take", int'(food_take), 1);
        check("ign_start_owner", int'(food_owner), 1);
        check("ign_start_len_b", int'(length_b), 5);
        check("ign_start_over", int'(game_over), 0);

        // Test 6: reset in SETTLE with pends armed
        wait_move("t6");
        step();
        repeat (10) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_state("t6_rst");
        n_ma = 0;
        n_mb = 0;
        repeat (30) step();
        check("t6_no_moves", n_ma + n_mb, 0);
        do_start();
        check_first_move("t6_restart");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
